// File: rtl/gpio_cfg_serializer.sv
// Purpose: source end of the GPIO pad-configuration serial chain; shifts a parallel image out MSB-first, then strobes serial_load.
// Latency: cfg_busy high for exactly (2*TOTAL+2)*CLK_DIV mclk cycles, followed by a one-cycle cfg_done pulse.
// Backpressure: none; cfg_start is only honoured in IDLE outside the cfg_done cycle, otherwise dropped (never queued).
//
// Ports:
//   mclk, resetn           system clock, asynchronous active-low reset
//   cfg_start              single-cycle start request
//   cfg_data               image, pad k at [k*PAD_CTRL_BITS +: PAD_CTRL_BITS], captured at start
//   cfg_busy, cfg_done     transfer in progress / completion pulse
//   serial_clock/_data     chain shift clock and data (data changes only while serial_clock is low)
//   serial_load            chain apply strobe, never high together with serial_clock
// Optional macro GPIO_CFG_READBACK_EN adds:
//   serial_data_ret        return data from the last pad's serial_data_out
//   cfg_rdata              image shifted out of the chain by the previous transfer, valid at cfg_done
module gpio_cfg_serializer #(
    parameter int NUM_PADS      = 14,
    parameter int PAD_CTRL_BITS = 12,
    parameter int CLK_DIV       = 4
) (
    input  logic                              mclk,
    input  logic                              resetn,
    input  logic                              cfg_start,
    input  logic [NUM_PADS*PAD_CTRL_BITS-1:0] cfg_data,
    output logic                              cfg_busy,
    output logic                              cfg_done,
    output logic                              serial_clock,
    output logic                              serial_data,
    output logic                              serial_load
`ifdef GPIO_CFG_READBACK_EN
    ,
    input  logic                              serial_data_ret,
    output logic [NUM_PADS*PAD_CTRL_BITS-1:0] cfg_rdata
`endif
);

    localparam int TOTAL = NUM_PADS * PAD_CTRL_BITS;
    localparam int BW    = $clog2(TOTAL + 1);
    localparam int PW    = $clog2(CLK_DIV + 1);

    localparam logic [BW-1:0] BIT_LAST = BW'(TOTAL - 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_LOAD_SETUP,
        ST_LOAD
    } state_t;

    state_t           r_state,   w_state_nxt;
    logic [PW-1:0]    r_phase,   w_phase_nxt;
    logic [BW-1:0]    r_bit_cnt, w_bit_cnt_nxt;
    logic [TOTAL-1:0] r_shadow,  w_shadow_nxt;
    logic             r_busy,    w_busy_nxt;
    logic             r_done,    w_done_nxt;
    logic             r_sclk,    w_sclk_nxt;
    logic             r_sdata,   w_sdata_nxt;
    logic             r_load,    w_load_nxt;
    logic             w_phase_end;

    assign w_phase_end = (r_phase == PH_LAST);

    always_ff @(posedge mclk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_phase   <= '0;
            r_bit_cnt <= '0;
            r_shadow  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sclk    <= 1'b0;
            r_sdata   <= 1'b0;
            r_load    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_phase   <= w_phase_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shadow  <= w_shadow_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_sclk    <= w_sclk_nxt;
            r_sdata   <= w_sdata_nxt;
            r_load    <= w_load_nxt;
        end
    end

    // Every output is computed here as the value it must hold in the next
    // cycle, so the registered outputs line up exactly with the state they
    // belong to. The phase counter wraps on every state change, giving each
    // non-idle state exactly CLK_DIV cycles.
    always_comb begin
        w_state_nxt   = r_state;
        w_phase_nxt   = w_phase_end ? '0 : r_phase + 1'b1;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shadow_nxt  = r_shadow;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_sclk_nxt    = r_sclk;
        w_sdata_nxt   = r_sdata;
        w_load_nxt    = r_load;

        case (r_state)
            ST_IDLE: begin
                w_phase_nxt = '0;
                // The cfg_done cycle is already IDLE but still counts as busy
                // for start requests, hence the r_done gate.
                if (cfg_start && !r_done) begin
                    w_state_nxt   = ST_SHIFT_LO;
                    w_busy_nxt    = 1'b1;
                    w_bit_cnt_nxt = '0;
                    w_sclk_nxt    = 1'b0;
                    w_sdata_nxt   = cfg_data[TOTAL-1];
                    // Shadow holds the bits still to be sent, next one at the top.
                    w_shadow_nxt  = cfg_data << 1;
                end
            end

            ST_SHIFT_LO: begin
                if (w_phase_end) begin
                    w_state_nxt = ST_SHIFT_HI;
                    w_sclk_nxt  = 1'b1;
                end
            end

            ST_SHIFT_HI: begin
                if (w_phase_end) begin
                    w_sclk_nxt    = 1'b0;
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == BIT_LAST) begin
                        w_state_nxt = ST_LOAD_SETUP;
                        w_sdata_nxt = 1'b0;
                    end else begin
                        // Data only moves on SHIFT_LO entry, i.e. together
                        // with the falling serial_clock edge.
                        w_state_nxt  = ST_SHIFT_LO;
                        w_sdata_nxt  = r_shadow[TOTAL-1];
                        w_shadow_nxt = r_shadow << 1;
                    end
                end
            end

            ST_LOAD_SETUP: begin
                if (w_phase_end) begin
                    w_state_nxt = ST_LOAD;
                    w_load_nxt  = 1'b1;
                end
            end

            ST_LOAD: begin
                if (w_phase_end) begin
                    w_state_nxt   = ST_IDLE;
                    w_load_nxt    = 1'b0;
                    w_busy_nxt    = 1'b0;
                    w_done_nxt    = 1'b1;
                    w_bit_cnt_nxt = '0;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
                w_sclk_nxt  = 1'b0;
                w_sdata_nxt = 1'b0;
                w_load_nxt  = 1'b0;
            end
        endcase
    end

    assign cfg_busy     = r_busy;
    assign cfg_done     = r_done;
    assign serial_clock = r_sclk;
    assign serial_data  = r_sdata;
    assign serial_load  = r_load;

`ifdef GPIO_CFG_READBACK_EN
    // The return bit is taken on the last mclk of each low phase, i.e. just
    // before the chain shifts on the rising serial_clock edge. After TOTAL
    // samples the first one has reached the MSB.
    logic [TOTAL-1:0] r_rdata;
    logic [TOTAL:0]   w_rdata_ext;
    logic             w_capture;

    assign w_rdata_ext = {r_rdata, serial_data_ret};
    assign w_capture   = (r_state == ST_SHIFT_LO) && w_phase_end;

    always_ff @(posedge mclk or negedge resetn) begin
        if (!resetn) begin
            r_rdata <= '0;
        end else if (w_capture) begin
            r_rdata <= w_rdata_ext[TOTAL-1:0];
        end
    end

    assign cfg_rdata = r_rdata;
`endif

endmodule

// File: tb/tb_gpio_cfg_serializer.sv
// Purpose: self-checking bench for gpio_cfg_serializer, a small (2x12, CLK_DIV=2) and a default-sized instance.
// Latency: expected busy length is (2*TOTAL+2)*CLK_DIV, bit streams come from the image MSB-first.
// Backpressure: start requests during busy or on the done cycle must be dropped.
module tb_gpio_cfg_serializer;

    localparam int S_DIV  = 2;
    localparam int S_TOT  = 24;
    localparam int S_BUSY = (2 * S_TOT + 2) * S_DIV;
    localparam int D_DIV  = 4;
    localparam int D_TOT  = 168;
    localparam int D_BUSY = (2 * D_TOT + 2) * D_DIV;

    logic mclk   = 1'b0;
    logic resetn = 1'b1;
    always #5 mclk = ~mclk;

    logic              s_start = 1'b0;
    logic [S_TOT-1:0]  s_data  = '0;
    logic              s_busy, s_done, s_sclk, s_sdata, s_load;
    logic              d_start = 1'b0;
    logic [D_TOT-1:0]  d_data  = '0;
    logic              d_busy, d_done, d_sclk, d_sdata, d_load;

`ifdef GPIO_CFG_READBACK_EN
    logic [S_TOT-1:0]  s_rdata;
    logic [D_TOT-1:0]  d_rdata;
    logic              d_ret = 1'b0;
    logic [S_TOT-1:0]  chain = '0;
    logic              s_ret;
    // Behavioural chain: 24 flops shifting on the rising serial clock.
    always @(posedge s_sclk) chain <= {chain[S_TOT-2:0], s_sdata};
    assign s_ret = chain[S_TOT-1];
`endif

    gpio_cfg_serializer #(.NUM_PADS(2), .PAD_CTRL_BITS(12), .CLK_DIV(S_DIV)) u_small (
        .mclk(mclk), .resetn(resetn), .cfg_start(s_start), .cfg_data(s_data),
        .cfg_busy(s_busy), .cfg_done(s_done), .serial_clock(s_sclk),
        .serial_data(s_sdata), .serial_load(s_load)
`ifdef GPIO_CFG_READBACK_EN
        , .serial_data_ret(s_ret), .cfg_rdata(s_rdata)
`endif
    );

    gpio_cfg_serializer #(.NUM_PADS(14), .PAD_CTRL_BITS(12), .CLK_DIV(D_DIV)) u_dflt (
        .mclk(mclk), .resetn(resetn), .cfg_start(d_start), .cfg_data(d_data),
        .cfg_busy(d_busy), .cfg_done(d_done), .serial_clock(d_sclk),
        .serial_data(d_sdata), .serial_load(d_load)
`ifdef GPIO_CFG_READBACK_EN
        , .serial_data_ret(d_ret), .cfg_rdata(d_rdata)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Observers of the serial interface, sampled on the falling mclk edge.
    int   s_cyc = 0, s_edges = 0, s_busy_cyc = 0, s_done_cyc = 0, s_load_cyc = 0;
    int   s_overlap = 0, s_dchg = 0, s_last_fall = 0, s_load_gap = 0;
    logic s_prev_clk = 1'b0, s_prev_dat = 1'b0, s_prev_load = 1'b0;
    bit   s_q[$];

    always @(negedge mclk) begin
        s_cyc       <= s_cyc + 1;
        s_prev_clk  <= s_sclk;
        s_prev_dat  <= s_sdata;
        s_prev_load <= s_load;
        if (s_sclk && !s_prev_clk) begin
            s_edges <= s_edges + 1;
            s_q.push_back(s_sdata);
        end
        if (!s_sclk && s_prev_clk) s_last_fall <= s_cyc;
        if (s_sclk && (s_sdata !== s_prev_dat)) s_dchg <= s_dchg + 1;
        if (s_load && !s_prev_load) s_load_gap <= s_cyc - s_last_fall;
        if (s_busy) s_busy_cyc <= s_busy_cyc + 1;
        if (s_done) s_done_cyc <= s_done_cyc + 1;
        if (s_load) s_load_cyc <= s_load_cyc + 1;
        if (s_load && s_sclk) s_overlap <= s_overlap + 1;
    end

    int   d_edges = 0, d_busy_cyc = 0, d_done_cyc = 0, d_hi_cyc = 0, d_overlap = 0;
    logic d_prev_clk = 1'b0;
    bit   d_q[$];

    always @(negedge mclk) begin
        d_prev_clk <= d_sclk;
        if (d_sclk && !d_prev_clk) begin
            d_edges <= d_edges + 1;
            d_q.push_back(d_sdata);
        end
        if (d_busy)  d_busy_cyc <= d_busy_cyc + 1;
        if (d_done)  d_done_cyc <= d_done_cyc + 1;
        if (d_sdata) d_hi_cyc   <= d_hi_cyc + 1;
        if (d_load && d_sclk) d_overlap <= d_overlap + 1;
    end

    // Stimulus helpers (no checking inside).
    task automatic s_pulse(input logic [S_TOT-1:0] img);
        @(negedge mclk);
        s_data  = img;
        s_start = 1'b1;
        @(negedge mclk);
        s_start = 1'b0;
    endtask

    task automatic s_wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge mclk);
            if (s_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [S_TOT-1:0] s_bits_from(input int q0);
        logic [S_TOT-1:0] v;
        v = '0;
        for (int i = 0; i < S_TOT; i++)
            if (q0 + i < s_q.size()) v = {v[S_TOT-2:0], s_q[q0 + i]};
        return v;
    endfunction

    task automatic test_reset();
        int bad;
        int e0;
        #2 resetn = 1'b0;
        repeat (3) @(negedge mclk);
        n_checks++;
        if ({s_busy, s_done, s_sclk, s_sdata, s_load} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_small outputs=%b expected=00000", {s_busy, s_done, s_sclk, s_sdata, s_load});
        end
        n_checks++;
        if ({d_busy, d_done, d_sclk, d_sdata, d_load} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_default outputs=%b expected=00000", {d_busy, d_done, d_sclk, d_sdata, d_load});
        end
        resetn = 1'b1;
        e0  = s_edges;
        bad = 0;
        repeat (20) begin
            @(negedge mclk);
            if ({s_busy, s_done, s_sclk, s_sdata, s_load, d_busy, d_sclk, d_load} !== 8'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL idle_outputs nonzero_cycles=%0d expected=0", bad);
        end
        n_checks++;
        if (s_edges != e0) begin
            n_fail++;
            $display("FAIL idle_edges got=%0d expected=0", s_edges - e0);
        end
`ifdef GPIO_CFG_READBACK_EN
        n_checks++;
        if (s_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_rdata got=%h expected=0", s_rdata);
        end
`endif
    endtask

    task automatic test_single();
        logic [S_TOT-1:0] img;
        int e0, q0, b0, dn0, l0, ov0, dc0;
        bit ok;
        img = 24'hA5C3F0;
        e0 = s_edges; q0 = s_q.size(); b0 = s_busy_cyc; dn0 = s_done_cyc;
        l0 = s_load_cyc; ov0 = s_overlap; dc0 = s_dchg;
        s_pulse(img);
        s_wait_done(S_BUSY + 20, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL single_timeout done_seen=0 expected=1");
        end
        n_checks++;
        if ({s_busy, s_load, s_sclk} !== 3'b000) begin
            n_fail++;
            $display("FAIL single_done_cycle busy_load_clk=%b expected=000", {s_busy, s_load, s_sclk});
        end
        repeat (3) @(negedge mclk);
        n_checks++;
        if (s_edges - e0 != S_TOT) begin
            n_fail++;
            $display("FAIL single_edges got=%0d expected=%0d", s_edges - e0, S_TOT);
        end
        n_checks++;
        if (s_bits_from(q0) !== img) begin
            n_fail++;
            $display("FAIL single_bits got=%h expected=%h", s_bits_from(q0), img);
        end
        n_checks++;
        if (s_load_cyc - l0 != S_DIV) begin
            n_fail++;
            $display("FAIL single_load_len got=%0d expected=%0d", s_load_cyc - l0, S_DIV);
        end
        n_checks++;
        if (s_load_gap != S_DIV) begin
            n_fail++;
            $display("FAIL single_load_gap got=%0d expected=%0d", s_load_gap, S_DIV);
        end
        n_checks++;
        if (s_busy_cyc - b0 != S_BUSY) begin
            n_fail++;
            $display("FAIL single_busy got=%0d expected=%0d", s_busy_cyc - b0, S_BUSY);
        end
        n_checks++;
        if (s_done_cyc - dn0 != 1) begin
            n_fail++;
            $display("FAIL single_done_pulses got=%0d expected=1", s_done_cyc - dn0);
        end
        n_checks++;
        if ((s_overlap - ov0) + (s_dchg - dc0) != 0) begin
            n_fail++;
            $display("FAIL single_timing overlap=%0d data_change_at_high=%0d expected=0", s_overlap - ov0, s_dchg - dc0);
        end
    endtask

    task automatic test_random();
        logic [S_TOT-1:0] img;
        int q0, b0;
        bit ok;
        for (int n = 0; n < 4; n++) begin
            img = S_TOT'($urandom);
            q0 = s_q.size(); b0 = s_busy_cyc;
            s_pulse(img);
            s_wait_done(S_BUSY + 20, ok);
            repeat (3) @(negedge mclk);
            n_checks++;
            if (!ok || s_bits_from(q0) !== img) begin
                n_fail++;
                $display("FAIL random_bits[%0d] got=%h expected=%h done=%0d", n, s_bits_from(q0), img, ok);
            end
            n_checks++;
            if (s_busy_cyc - b0 != S_BUSY) begin
                n_fail++;
                $display("FAIL random_busy[%0d] got=%0d expected=%0d", n, s_busy_cyc - b0, S_BUSY);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [S_TOT-1:0] img_a, img_b;
        int q0, b0, dn0, bad;
        bit ok;
        img_a = S_TOT'($urandom);
        img_b = ~img_a;
        q0 = s_q.size(); b0 = s_busy_cyc; dn0 = s_done_cyc;
        s_pulse(img_a);
        repeat (4) @(negedge mclk);
        s_data  = img_b;
        s_start = 1'b1;
        @(negedge mclk);
        s_start = 1'b0;
        s_wait_done(S_BUSY + 20, ok);
        // Request on the cfg_done cycle itself.
        s_start = 1'b1;
        @(negedge mclk);
        s_start = 1'b0;
        bad = 0;
        repeat (4) begin
            if (s_busy !== 1'b0) bad++;
            @(negedge mclk);
        end
        n_checks++;
        if (!ok || bad != 0) begin
            n_fail++;
            $display("FAIL ignore_done_cycle busy_cycles=%0d expected=0 done=%0d", bad, ok);
        end
        n_checks++;
        if (s_bits_from(q0) !== img_a) begin
            n_fail++;
            $display("FAIL ignore_bits got=%h expected=%h", s_bits_from(q0), img_a);
        end
        n_checks++;
        if (s_busy_cyc - b0 != S_BUSY || s_done_cyc - dn0 != 1) begin
            n_fail++;
            $display("FAIL ignore_busy busy=%0d done=%0d expected=%0d/1", s_busy_cyc - b0, s_done_cyc - dn0, S_BUSY);
        end
    endtask

    task automatic test_back_to_back();
        logic [S_TOT-1:0] img_a, img_b;
        int q0, e0, dn0;
        bit ok1, ok2;
        img_a = S_TOT'($urandom);
        img_b = S_TOT'($urandom);
        q0 = s_q.size(); e0 = s_edges; dn0 = s_done_cyc;
        s_pulse(img_a);
        s_wait_done(S_BUSY + 20, ok1);
        @(negedge mclk);
        s_data  = img_b;
        s_start = 1'b1;
        @(negedge mclk);
        s_start = 1'b0;
        n_checks++;
        if (s_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_restart busy=%b expected=1", s_busy);
        end
        s_wait_done(S_BUSY + 20, ok2);
        repeat (3) @(negedge mclk);
        n_checks++;
        if (!ok1 || !ok2 || s_edges - e0 != 2 * S_TOT || s_done_cyc - dn0 != 2) begin
            n_fail++;
            $display("FAIL b2b_counts edges=%0d done=%0d expected=%0d/2", s_edges - e0, s_done_cyc - dn0, 2 * S_TOT);
        end
        n_checks++;
        if (s_bits_from(q0 + S_TOT) !== img_b) begin
            n_fail++;
            $display("FAIL b2b_bits got=%h expected=%h", s_bits_from(q0 + S_TOT), img_b);
        end
    endtask

    task automatic test_reset_mid();
        logic [S_TOT-1:0] img;
        int e0, l0, q0, bad;
        bit ok;
        e0 = s_edges; l0 = s_load_cyc;
        s_pulse(S_TOT'($urandom));
        for (int i = 0; i < S_BUSY && (s_edges - e0) < 10; i++) @(negedge mclk);
        #2 resetn = 1'b0;
        #1;
        n_checks++;
        if ({s_busy, s_done, s_sclk, s_sdata, s_load} !== 5'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs got=%b expected=00000", {s_busy, s_done, s_sclk, s_sdata, s_load});
        end
        repeat (3) @(negedge mclk);
        resetn = 1'b1;
        bad = 0;
        repeat (S_BUSY) begin
            @(negedge mclk);
            if (s_busy || s_load) bad++;
        end
        n_checks++;
        if (s_load_cyc != l0 || bad != 0 || s_edges - e0 < 10) begin
            n_fail++;
            $display("FAIL midreset_abort load=%0d busy_after=%0d edges=%0d expected=0/0/>=10", s_load_cyc - l0, bad, s_edges - e0);
        end
        img = S_TOT'($urandom);
        q0  = s_q.size();
        s_pulse(img);
        s_wait_done(S_BUSY + 20, ok);
        repeat (3) @(negedge mclk);
        n_checks++;
        if (!ok || s_bits_from(q0) !== img) begin
            n_fail++;
            $display("FAIL midreset_next got=%h expected=%h done=%0d", s_bits_from(q0), img, ok);
        end
    endtask

    task automatic test_default();
        logic [D_TOT-1:0] img, got;
        int e0, q0, b0, dn0, h0, ov0;
        bit ok;
        for (int n = 0; n < 2; n++) begin
            img = '0;
            if (n == 0) img[0] = 1'b1;
            else for (int w = 0; w < 6; w++) img = {img[D_TOT-33:0], 32'($urandom)};
            e0 = d_edges; q0 = d_q.size(); b0 = d_busy_cyc; dn0 = d_done_cyc;
            h0 = d_hi_cyc; ov0 = d_overlap;
            @(negedge mclk);
            d_data  = img;
            d_start = 1'b1;
            @(negedge mclk);
            d_start = 1'b0;
            ok = 1'b0;
            for (int i = 0; i < D_BUSY + 20 && !ok; i++) begin
                @(negedge mclk);
                if (d_done) ok = 1'b1;
            end
            repeat (3) @(negedge mclk);
            got = '0;
            for (int i = 0; i < D_TOT; i++)
                if (q0 + i < d_q.size()) got = {got[D_TOT-2:0], d_q[q0 + i]};
            n_checks++;
            if (!ok || d_busy_cyc - b0 != D_BUSY || d_done_cyc - dn0 != 1) begin
                n_fail++;
                $display("FAIL default_busy[%0d] busy=%0d done=%0d expected=%0d/1", n, d_busy_cyc - b0, d_done_cyc - dn0, D_BUSY);
            end
            n_checks++;
            if (d_edges - e0 != D_TOT || got !== img) begin
                n_fail++;
                $display("FAIL default_bits[%0d] edges=%0d got=%h expected=%h", n, d_edges - e0, got, img);
            end
            n_checks++;
            if (d_overlap != ov0) begin
                n_fail++;
                $display("FAIL default_overlap[%0d] got=%0d expected=0", n, d_overlap - ov0);
            end
            if (n == 0) begin
                n_checks++;
                if (d_hi_cyc - h0 != 2 * D_DIV) begin
                    n_fail++;
                    $display("FAIL default_data_high got=%0d expected=%0d", d_hi_cyc - h0, 2 * D_DIV);
                end
            end
        end
    endtask

`ifdef GPIO_CFG_READBACK_EN
    task automatic test_readback();
        logic [S_TOT-1:0] first_img [2];
        logic [S_TOT-1:0] second_img [2];
        bit ok1, ok2;
        first_img[0]  = 24'h123456;
        second_img[0] = 24'h000000;
        first_img[1]  = S_TOT'($urandom);
        second_img[1] = S_TOT'($urandom);
        for (int n = 0; n < 2; n++) begin
            s_pulse(first_img[n]);
            s_wait_done(S_BUSY + 20, ok1);
            s_pulse(second_img[n]);
            s_wait_done(S_BUSY + 20, ok2);
            n_checks++;
            if (!ok1 || !ok2 || s_rdata !== first_img[n]) begin
                n_fail++;
                $display("FAIL readback[%0d] got=%h expected=%h", n, s_rdata, first_img[n]);
            end
            repeat (5) @(negedge mclk);
            n_checks++;
            if (s_rdata !== first_img[n]) begin
                n_fail++;
                $display("FAIL readback_hold[%0d] got=%h expected=%h", n, s_rdata, first_img[n]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_default();
`ifdef GPIO_CFG_READBACK_EN
        test_readback();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end

endmodule
